// File: rtl/ctrl_pipe_unit_if.sv
// Bus between the fetch/ID side and the pipelined control unit: the ID-stage
// instruction and pipeline controls in, the EX/MEM control bundles out.
interface ctrl_pipe_unit_if #(
    parameter int ILL_CNT_W = 8
);
    // ID-stage inputs
    logic                 inst_valid;
    logic [31:0]          inst;
    logic                 stall_in;
    logic                 flush;

    // Hazard hold towards PC and IF/ID
    logic                 id_stall;

    // EX-stage control
    logic                 ex_valid;
    logic                 ex_reg_write;
    logic                 ex_mem_to_reg;
    logic                 ex_pc_plus8;
    logic                 ex_alu_reg_sel;
    logic                 ex_illegal;
    logic [2:0]           ex_alu_src_b;
    logic [2:0]           ex_ldst;
    logic [3:0]           ex_jump_branch;
    logic [4:0]           ex_wdest;
    logic [5:0]           ex_opcode;
    logic [5:0]           ex_funct;

    // MEM-stage control
    logic                 mem_valid;
    logic                 mem_reg_write;
    logic                 mem_mem_to_reg;
    logic [2:0]           mem_ldst;
    logic [4:0]           mem_wdest;

    // Saturating illegal-instruction count
    logic [ILL_CNT_W-1:0] ill_count;

    // Fetch/ID side: supplies instructions, consumes the control bundles
    modport master (
        output inst_valid, inst, stall_in, flush,
        input  id_stall,
        input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_pc_plus8, ex_alu_reg_sel,
        input  ex_illegal, ex_alu_src_b, ex_ldst, ex_jump_branch, ex_wdest,
        input  ex_opcode, ex_funct,
        input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_ldst, mem_wdest,
        input  ill_count
    );

    // Control unit side
    modport slave (
        input  inst_valid, inst, stall_in, flush,
        output id_stall,
        output ex_valid, ex_reg_write, ex_mem_to_reg, ex_pc_plus8, ex_alu_reg_sel,
        output ex_illegal, ex_alu_src_b, ex_ldst, ex_jump_branch, ex_wdest,
        output ex_opcode, ex_funct,
        output mem_valid, mem_reg_write, mem_mem_to_reg, mem_ldst, mem_wdest,
        output ill_count
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined MIPS-I control unit: decodes the ID instruction into the control
// bundle, registers it into EX and MEM, handles load-use interlock, bubbles,
// branch flushes (including flushes raised during an external stall) and a
// saturating illegal-instruction counter.
module ctrl_pipe_unit #(
    parameter bit HAZARD_EN        = 1'b1,
    parameter int ILL_CNT_W        = 8,
    parameter bit ZERO_WB_SUPPRESS = 1'b1
) (
    input logic             clk,
    input logic             rst,
    ctrl_pipe_unit_if.slave bus
);

    // MIPS-I primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_SRA    = 6'b000011;
    localparam logic [5:0] FN_SLLV   = 6'b000100;
    localparam logic [5:0] FN_SRLV   = 6'b000110;
    localparam logic [5:0] FN_SRAV   = 6'b000111;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_XOR    = 6'b100110;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_SLTU   = 6'b101011;

    // ALU operand-B selects
    localparam logic [2:0] SRCB_RT    = 3'b000;
    localparam logic [2:0] SRCB_RS    = 3'b001;
    localparam logic [2:0] SRCB_SEXT  = 3'b010;
    localparam logic [2:0] SRCB_ZEXT  = 3'b011;
    localparam logic [2:0] SRCB_ZERO  = 3'b100;
    localparam logic [2:0] SRCB_SHAMT = 3'b101;

    // Load/store kinds
    localparam logic [2:0] LDST_LB  = 3'b000;
    localparam logic [2:0] LDST_LH  = 3'b001;
    localparam logic [2:0] LDST_LW  = 3'b010;
    localparam logic [2:0] LDST_LBU = 3'b011;
    localparam logic [2:0] LDST_LHU = 3'b100;
    localparam logic [2:0] LDST_SB  = 3'b101;
    localparam logic [2:0] LDST_SH  = 3'b110;
    localparam logic [2:0] LDST_SW  = 3'b111;

    // Jump/branch kinds
    localparam logic [3:0] JB_NONE = 4'b0000;
    localparam logic [3:0] JB_J    = 4'b0001;
    localparam logic [3:0] JB_JR   = 4'b0010;
    localparam logic [3:0] JB_BEQ  = 4'b0011;
    localparam logic [3:0] JB_BNE  = 4'b0100;
    localparam logic [3:0] JB_BLEZ = 4'b0101;
    localparam logic [3:0] JB_BGTZ = 4'b0110;
    localparam logic [3:0] JB_BLTZ = 4'b0111;
    localparam logic [3:0] JB_BGEZ = 4'b1000;

    // Full EX-stage bundle; all-zero is a bubble
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_plus8;
        logic       alu_reg_sel;
        logic       illegal;
        logic [2:0] alu_src_b;
        logic [2:0] ldst;
        logic [3:0] jump_branch;
        logic [4:0] wdest;
        logic [5:0] opcode;
        logic [5:0] funct;
    } ex_ctrl_t;

    // Subset of the bundle still needed in MEM
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] ldst;
        logic [4:0] wdest;
    } mem_ctrl_t;

    // Instruction fields
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op = bus.inst[31:26];
    assign rs = bus.inst[25:21];
    assign rt = bus.inst[20:16];
    assign rd = bus.inst[15:11];
    assign fn = bus.inst[5:0];
    // The shift amount travels to the datapath directly; control never looks at it.
    assign unused_shamt = ^bus.inst[10:6];

    ex_ctrl_t             dec;
    logic                 legal;
    logic                 rs_used;
    logic                 rt_used;
    logic                 load_use;
    logic                 id_stall;

    ex_ctrl_t             ex_q,         ex_d;
    mem_ctrl_t            mem_q,        mem_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [ILL_CNT_W-1:0] ill_count_q,  ill_count_d;

    // Combinational decode of the ID instruction into a full control bundle
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        dec        = '0;
        legal      = 1'b1;
        dec.valid  = 1'b1;
        dec.opcode = op;
        dec.funct  = fn;
        dec.wdest  = rt;
        case (op)
            OP_RTYPE: begin
                dec.wdest     = rd;
                dec.reg_write = 1'b1;
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.alu_src_b   = SRCB_SHAMT;
                        dec.alu_reg_sel = 1'b1;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        dec.alu_src_b   = SRCB_RS;
                        dec.alu_reg_sel = 1'b1;
                    end
                    FN_JR: begin
                        dec.jump_branch = JB_JR;
                        dec.reg_write   = 1'b0;
                    end
                    FN_JALR: begin
                        dec.jump_branch = JB_JR;
                        dec.pc_plus8    = 1'b1;
                    end
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: ;
                    default: legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                dec.alu_src_b = SRCB_ZERO;
                case (rt)
                    5'b00000: dec.jump_branch = JB_BLTZ;
                    5'b00001: dec.jump_branch = JB_BGEZ;
                    default:  legal = 1'b0;
                endcase
            end
            OP_J: begin
                dec.wdest       = 5'd0;
                dec.jump_branch = JB_J;
            end
            OP_JAL: begin
                dec.wdest       = 5'd31;
                dec.jump_branch = JB_J;
                dec.pc_plus8    = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OP_BEQ:  dec.jump_branch = JB_BEQ;
            OP_BNE:  dec.jump_branch = JB_BNE;
            OP_BLEZ: begin
                dec.jump_branch = JB_BLEZ;
                dec.alu_src_b   = SRCB_ZERO;
            end
            OP_BGTZ: begin
                dec.jump_branch = JB_BGTZ;
                dec.alu_src_b   = SRCB_ZERO;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.alu_src_b = SRCB_SEXT;
                dec.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src_b = SRCB_ZEXT;
                dec.reg_write = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.alu_src_b  = SRCB_SEXT;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                case (op)
                    OP_LH:   dec.ldst = LDST_LH;
                    OP_LW:   dec.ldst = LDST_LW;
                    OP_LBU:  dec.ldst = LDST_LBU;
                    OP_LHU:  dec.ldst = LDST_LHU;
                    default: dec.ldst = LDST_LB;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.alu_src_b = SRCB_SEXT;
                case (op)
                    OP_SB:   dec.ldst = LDST_SB;
                    OP_SH:   dec.ldst = LDST_SH;
                    default: dec.ldst = LDST_SW;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (ZERO_WB_SUPPRESS && (dec.wdest == 5'd0)) begin
            dec.reg_write = 1'b0;
        end

        // An illegal word carries nothing but its valid/illegal marking
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    // Source-register usage, judged on the raw encoding fields
    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        case (op)
            OP_J, OP_JAL, OP_LUI: rs_used = 1'b0;
            OP_RTYPE: begin
                if ((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA)) begin
                    rs_used = 1'b0;
                end
                rt_used = (fn != FN_JR) && (fn != FN_JALR);
            end
            OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: rt_used = 1'b1;
            default: ;
        endcase
    end

    // A load in EX whose destination feeds the ID instruction must wait one cycle
    assign load_use = HAZARD_EN && bus.inst_valid && ex_q.valid && ex_q.mem_to_reg &&
                      (ex_q.wdest != 5'd0) &&
                      ((rs_used && (rs == ex_q.wdest)) || (rt_used && (rt == ex_q.wdest)));

    // Pipeline advance: external stall, then flush, then load-use, then normal issue
    always_comb begin
        ex_d         = ex_q;
        mem_d        = mem_q;
        flush_pend_d = flush_pend_q;
        ill_count_d  = ill_count_q;
        id_stall     = 1'b0;
        if (bus.stall_in) begin
            // Everything holds; a flush seen now is replayed on the first free edge
            id_stall = 1'b1;
            if (bus.flush) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            mem_d.valid      = ex_q.valid;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.ldst       = ex_q.ldst;
            mem_d.wdest      = ex_q.wdest;
            if (bus.flush || flush_pend_q) begin
                ex_d         = '0;
                flush_pend_d = 1'b0;
            end else if (load_use) begin
                ex_d     = '0;
                id_stall = 1'b1;
            end else if (bus.inst_valid) begin
                ex_d = dec;
                if (dec.illegal && (ill_count_q != '1)) begin
                    ill_count_d = ill_count_q + ILL_CNT_W'(1);
                end
            end else begin
                ex_d = '0;
            end
        end
    end

    // Pipeline registers and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            flush_pend_q <= 1'b0;
            ill_count_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            flush_pend_q <= flush_pend_d;
            ill_count_q  <= ill_count_d;
        end
    end

    assign bus.id_stall       = id_stall;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
    assign bus.ex_pc_plus8    = ex_q.pc_plus8;
    assign bus.ex_alu_reg_sel = ex_q.alu_reg_sel;
    assign bus.ex_illegal     = ex_q.illegal;
    assign bus.ex_alu_src_b   = ex_q.alu_src_b;
    assign bus.ex_ldst        = ex_q.ldst;
    assign bus.ex_jump_branch = ex_q.jump_branch;
    assign bus.ex_wdest       = ex_q.wdest;
    assign bus.ex_opcode      = ex_q.opcode;
    assign bus.ex_funct       = ex_q.funct;
    assign bus.mem_valid      = mem_q.valid;
    assign bus.mem_reg_write  = mem_q.reg_write;
    assign bus.mem_mem_to_reg = mem_q.mem_to_reg;
    assign bus.mem_ldst       = mem_q.ldst;
    assign bus.mem_wdest      = mem_q.wdest;
    assign bus.ill_count      = ill_count_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: two instances (default parameters, and interlock
// off / no $0 suppression / 4-bit counter) share one input stream and are
// compared against a mnemonic-level reference model every cycle.
module tb_ctrl_pipe_unit;

    typedef enum {
        M_ILL, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
        M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ,
        M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW
    } mn_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_plus8;
        logic       alu_reg_sel;
        logic       illegal;
        logic [2:0] alu_src_b;
        logic [2:0] ldst;
        logic [3:0] jb;
        logic [4:0] wdest;
        logic [5:0] opcode;
        logic [5:0] funct;
    } bnd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.ILL_CNT_W(8)) ifa ();
    ctrl_pipe_unit_if #(.ILL_CNT_W(4)) ifb ();

    assign ifa.inst_valid = inst_valid;
    assign ifa.inst       = inst;
    assign ifa.stall_in   = stall_in;
    assign ifa.flush      = flush;
    assign ifb.inst_valid = inst_valid;
    assign ifb.inst       = inst;
    assign ifb.stall_in   = stall_in;
    assign ifb.flush      = flush;

    ctrl_pipe_unit #(.HAZARD_EN(1'b1), .ILL_CNT_W(8), .ZERO_WB_SUPPRESS(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    ctrl_pipe_unit #(.HAZARD_EN(1'b0), .ILL_CNT_W(4), .ZERO_WB_SUPPRESS(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Observed outputs gathered per instance
    bnd_t        o_ex    [2];
    logic [10:0] o_mem   [2];
    int          o_cnt   [2];
    logic        o_stall [2];

    assign o_ex[0] = {ifa.ex_valid, ifa.ex_reg_write, ifa.ex_mem_to_reg, ifa.ex_pc_plus8,
                      ifa.ex_alu_reg_sel, ifa.ex_illegal, ifa.ex_alu_src_b, ifa.ex_ldst,
                      ifa.ex_jump_branch, ifa.ex_wdest, ifa.ex_opcode, ifa.ex_funct};
    assign o_ex[1] = {ifb.ex_valid, ifb.ex_reg_write, ifb.ex_mem_to_reg, ifb.ex_pc_plus8,
                      ifb.ex_alu_reg_sel, ifb.ex_illegal, ifb.ex_alu_src_b, ifb.ex_ldst,
                      ifb.ex_jump_branch, ifb.ex_wdest, ifb.ex_opcode, ifb.ex_funct};
    assign o_mem[0] = {ifa.mem_valid, ifa.mem_reg_write, ifa.mem_mem_to_reg, ifa.mem_ldst, ifa.mem_wdest};
    assign o_mem[1] = {ifb.mem_valid, ifb.mem_reg_write, ifb.mem_mem_to_reg, ifb.mem_ldst, ifb.mem_wdest};
    assign o_cnt[0] = 32'(ifa.ill_count);
    assign o_cnt[1] = 32'(ifb.ill_count);
    assign o_stall[0] = ifa.id_stall;
    assign o_stall[1] = ifb.id_stall;

    // Reference model state and per-instance configuration
    bnd_t m_ex  [2];
    bnd_t m_mem [2];
    bit   m_fp  [2];
    int   m_cnt [2];
    bit   cfg_hazard [2] = '{1'b1, 1'b0};
    bit   cfg_zws    [2] = '{1'b1, 1'b0};
    int   cfg_cmax   [2] = '{255, 15};
    logic last_stall [2];

    logic [31:0] tmpl [26];

    function automatic mn_t classify(input logic [31:0] w);
        mn_t m;
        m = M_ILL;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h00: m = M_SLL;   6'h02: m = M_SRL;   6'h03: m = M_SRA;
                6'h04: m = M_SLLV;  6'h06: m = M_SRLV;  6'h07: m = M_SRAV;
                6'h08: m = M_JR;    6'h09: m = M_JALR;  6'h21: m = M_ADDU;
                6'h23: m = M_SUBU;  6'h24: m = M_AND;   6'h25: m = M_OR;
                6'h26: m = M_XOR;   6'h27: m = M_NOR;   6'h2A: m = M_SLT;
                6'h2B: m = M_SLTU;  default: m = M_ILL;
            endcase
            6'h01: m = (w[20:16] == 5'd0) ? M_BLTZ : ((w[20:16] == 5'd1) ? M_BGEZ : M_ILL);
            6'h02: m = M_J;     6'h03: m = M_JAL;   6'h04: m = M_BEQ;   6'h05: m = M_BNE;
            6'h06: m = M_BLEZ;  6'h07: m = M_BGTZ;  6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI;
            6'h0B: m = M_SLTIU; 6'h0C: m = M_ANDI;  6'h0D: m = M_ORI;   6'h0E: m = M_XORI;
            6'h0F: m = M_LUI;   6'h20: m = M_LB;    6'h21: m = M_LH;    6'h23: m = M_LW;
            6'h24: m = M_LBU;   6'h25: m = M_LHU;   6'h28: m = M_SB;    6'h29: m = M_SH;
            6'h2B: m = M_SW;
            default: m = M_ILL;
        endcase
        return m;
    endfunction

    function automatic bnd_t ref_decode(input logic [31:0] w, input bit zws);
        bnd_t b;
        mn_t  m;
        bit   is_load, is_store, is_branch;
        m = classify(w);
        b = '0;
        b.valid = 1'b1;
        if (m == M_ILL) begin
            b.illegal = 1'b1;
            return b;
        end
        is_load   = m inside {M_LB, M_LH, M_LW, M_LBU, M_LHU};
        is_store  = m inside {M_SB, M_SH, M_SW};
        is_branch = m inside {M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ};
        b.opcode = w[31:26];
        b.funct  = w[5:0];
        if (m inside {M_SLL, M_SRL, M_SRA})                              b.alu_src_b = 3'd5;
        else if (m inside {M_SLLV, M_SRLV, M_SRAV})                      b.alu_src_b = 3'd1;
        else if (is_load || is_store || m inside {M_ADDIU, M_SLTI, M_SLTIU}) b.alu_src_b = 3'd2;
        else if (m inside {M_ANDI, M_ORI, M_XORI, M_LUI})                b.alu_src_b = 3'd3;
        else if (m inside {M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ})              b.alu_src_b = 3'd4;
        b.alu_reg_sel = m inside {M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV};
        b.pc_plus8    = m inside {M_JAL, M_JALR};
        b.reg_write   = !(is_store || is_branch || m == M_J || m == M_JR);
        b.mem_to_reg  = is_load;
        case (m)
            M_LH: b.ldst = 3'd1;  M_LW: b.ldst = 3'd2;  M_LBU: b.ldst = 3'd3;
            M_LHU: b.ldst = 3'd4; M_SB: b.ldst = 3'd5;  M_SH: b.ldst = 3'd6;
            M_SW: b.ldst = 3'd7;  default: b.ldst = 3'd0;
        endcase
        case (m)
            M_J, M_JAL:  b.jb = 4'd1;  M_JR, M_JALR: b.jb = 4'd2;
            M_BEQ:  b.jb = 4'd3;  M_BNE:  b.jb = 4'd4;  M_BLEZ: b.jb = 4'd5;
            M_BGTZ: b.jb = 4'd6;  M_BLTZ: b.jb = 4'd7;  M_BGEZ: b.jb = 4'd8;
            default: b.jb = 4'd0;
        endcase
        if (w[31:26] == 6'd0) b.wdest = w[15:11];
        else if (m == M_JAL)  b.wdest = 5'd31;
        else if (m == M_J)    b.wdest = 5'd0;
        else                  b.wdest = w[20:16];
        if (zws && b.wdest == 5'd0) b.reg_write = 1'b0;
        return b;
    endfunction

    function automatic bit ref_hazard(input int k);
        mn_t m;
        bit  rs_u, rt_u;
        m    = classify(inst);
        rs_u = !(m inside {M_J, M_JAL, M_LUI, M_SLL, M_SRL, M_SRA});
        rt_u = (inst[31:26] == 6'd0 && !(m inside {M_JR, M_JALR})) ||
               (m inside {M_BEQ, M_BNE, M_SB, M_SH, M_SW});
        return cfg_hazard[k] && inst_valid && m_ex[k].valid && m_ex[k].mem_to_reg &&
               m_ex[k].wdest != 5'd0 &&
               ((rs_u && inst[25:21] == m_ex[k].wdest) || (rt_u && inst[20:16] == m_ex[k].wdest));
    endfunction

    function automatic bit ref_stall(input int k);
        return stall_in || (!(flush || m_fp[k]) && ref_hazard(k));
    endfunction

    task automatic model_edge(input int k);
        bit hz;
        hz = ref_hazard(k);
        if (stall_in) begin
            if (flush) m_fp[k] = 1'b1;
        end else begin
            m_mem[k] = m_ex[k];
            if (flush || m_fp[k]) begin
                m_ex[k] = '0;
                m_fp[k] = 1'b0;
            end else if (hz) begin
                m_ex[k] = '0;
            end else if (inst_valid) begin
                m_ex[k] = ref_decode(inst, cfg_zws[k]);
                if (m_ex[k].illegal && m_cnt[k] < cfg_cmax[k]) m_cnt[k]++;
            end else begin
                m_ex[k] = '0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k]  = '0;
            m_mem[k] = '0;
            m_fp[k]  = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/ex%0d", tag, k), 64'(o_ex[k]), 64'(m_ex[k]));
            chk($sformatf("%s/mem%0d", tag, k), 64'(o_mem[k]),
                64'({m_mem[k].valid, m_mem[k].reg_write, m_mem[k].mem_to_reg,
                     m_mem[k].ldst, m_mem[k].wdest}));
            chk($sformatf("%s/cnt%0d", tag, k), 64'(o_cnt[k]), 64'(m_cnt[k]));
        end
    endtask

    // One clock: apply inputs, check combinational stall, clock, check registers
    task automatic cycle(input bit v, input logic [31:0] w, input bit st, input bit fl);
        inst_valid = v;
        inst       = w;
        stall_in   = st;
        flush      = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            last_stall[k] = o_stall[k];
            chk($sformatf("id_stall%0d", k), 64'(o_stall[k]), 64'(ref_stall(k)));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        check_all("cyc");
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int unsigned r;
        r = $urandom_range(0, 29);
        if (r >= 26) return $urandom();
        w = tmpl[r];
        w = w | {6'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'd0};
        if (w[31:26] == 6'd0) w = w | {16'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 6'd0};
        else                  w = w | {16'd0, 16'($urandom())};
        return w;
    endfunction

    initial begin
        tmpl = '{32'h8C000000, 32'h80000000, 32'h84000000, 32'h90000000, 32'h94000000,
                 32'hA0000000, 32'hA4000000, 32'hAC000000, 32'h00000021, 32'h00000023,
                 32'h00000000, 32'h00000003, 32'h00000004, 32'h00000008, 32'h00000009,
                 32'h10000000, 32'h14000000, 32'h18000000, 32'h1C000000, 32'h04000000,
                 32'h08000000, 32'h0C000000, 32'h3C000000, 32'h30000000, 32'h28000000,
                 32'h8C000000};

        // Reset
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        chk("reset/id_stall", 64'(o_stall[0]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADDU $3,$1,$2 then one idle cycle
        cycle(1'b1, 32'h00221821, 1'b0, 1'b0);
        chk("addu/ex_valid", 64'(ifa.ex_valid), 64'd1);
        chk("addu/ex_reg_write", 64'(ifa.ex_reg_write), 64'd1);
        chk("addu/ex_wdest", 64'(ifa.ex_wdest), 64'd3);
        chk("addu/ex_alu_src_b", 64'(ifa.ex_alu_src_b), 64'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("addu/mem_wdest", 64'(ifa.mem_wdest), 64'd3);

        // LW $5,0($4) then ADDU $6,$5,$0 held one extra cycle by fetch
        cycle(1'b1, 32'h8C850000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00A03021, 1'b0, 1'b0);
        chk("lu/stall_a", 64'(last_stall[0]), 64'd1);
        chk("lu/stall_b", 64'(last_stall[1]), 64'd0);
        chk("lu/bubble_a", 64'(ifa.ex_valid), 64'd0);
        chk("lu/noint_b", 64'(ifb.ex_wdest), 64'd6);
        cycle(1'b1, 32'h00A03021, 1'b0, 1'b0);
        chk("lu/stall_clear", 64'(last_stall[0]), 64'd0);
        chk("lu/addu_ex", 64'(ifa.ex_wdest), 64'd6);

        // ORI $7 then three stalled cycles, flush in the second
        cycle(1'b1, 32'h34070001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h38080002, 1'b1, (i == 1));
            chk("stall/ex_frozen", 64'(ifa.ex_wdest), 64'd7);
            chk("stall/mem_frozen", 64'(ifa.mem_wdest), 64'd6);
        end
        cycle(1'b1, 32'h38080002, 1'b0, 1'b0);
        chk("pend/bubble", 64'(ifa.ex_valid), 64'd0);
        chk("pend/mem", 64'(ifa.mem_wdest), 64'd7);
        cycle(1'b1, 32'h38080002, 1'b0, 1'b0);
        chk("pend/cleared", 64'(ifa.ex_wdest), 64'd8);

        // REGIMM: BGEZ, then illegal rt, then many illegal words
        cycle(1'b1, 32'h04410004, 1'b0, 1'b0);
        chk("bgez/jb", 64'(ifa.ex_jump_branch), 64'h8);
        chk("bgez/srcb", 64'(ifa.ex_alu_src_b), 64'h4);
        cycle(1'b1, 32'h04420004, 1'b0, 1'b0);
        chk("regimm_ill/illegal", 64'(ifa.ex_illegal), 64'd1);
        chk("regimm_ill/count", 64'(ifa.ill_count), 64'd1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'hFC000000 | 32'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("sat/count_a", 64'(ifa.ill_count), 64'd255);
        chk("sat/count_b", 64'(ifb.ill_count), 64'd15);

        // ADDIU $0,$1,5 and JAL
        cycle(1'b1, 32'h24200005, 1'b0, 1'b0);
        chk("zero_wb/a", 64'(ifa.ex_reg_write), 64'd0);
        chk("zero_wb/b", 64'(ifb.ex_reg_write), 64'd1);
        cycle(1'b1, 32'h0C000100, 1'b0, 1'b0);
        chk("jal/wdest", 64'(ifa.ex_wdest), 64'd31);
        chk("jal/pc_plus8", 64'(ifa.ex_pc_plus8), 64'd1);
        chk("jal/jb", 64'(ifa.ex_jump_branch), 64'd1);

        // Asynchronous reset while a flush is pending and EX is valid
        cycle(1'b1, 32'h00221821, 1'b0, 1'b0);
        cycle(1'b1, 32'h00221821, 1'b1, 1'b1);
        chk("arst/ex_before", 64'(ifa.ex_valid), 64'd1);
        inst_valid = 1'b0;
        stall_in   = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst/ex_valid", 64'(ifa.ex_valid), 64'd0);
        chk("arst/id_stall", 64'(o_stall[0]), 64'd0);
        rst = 1'b0;
        #1;
        cycle(1'b1, 32'h00221821, 1'b0, 1'b0);
        chk("arst/no_bubble", 64'(ifa.ex_valid), 64'd1);

        // Randomized traffic with stalls, flushes and gaps
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) < 85), rand_inst(),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined, parametrised MIPS-I control unit for the 5-stage core. It decodes the ID-stage instruction into the team's control bundle and registers that bundle into the EX and MEM stages. Along the way it detects load-use hazards, inserts bubbles, and applies branch flushes, including flushes raised while the pipe is stalled. It also flags illegal instructions and keeps a saturating count of them. It sits between the fetch/ID register and the datapath. ALU op decode stays in ALUdec, which is fed from `ex_opcode`/`ex_funct`.

## Interface
- `HAZARD_EN`, 1: 1 enables the load-use interlock; 0 never stalls internally.
- `ILL_CNT_W`, 8: width of the illegal-instruction counter (1..32).
- `ZERO_WB_SUPPRESS`, 1: 1 forces reg_write to 0 when the destination is $0.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `inst_valid` in 1: `inst` holds a valid ID-stage instruction.
- `inst` in 32: the instruction word.
- `stall_in` in 1: external hold (memory busy); freezes EX and MEM registers.
- `flush` in 1: branch/jump resolved taken in EX; squashes the ID instruction.
- `id_stall` out 1: holds PC and the IF/ID register this cycle.
- `ex_valid`, `ex_reg_write`, `ex_mem_to_reg`, `ex_pc_plus8`, `ex_alu_reg_sel`, `ex_illegal` out 1 each: EX-stage control.
- `ex_alu_src_b` out 3: 000 RT, 001 RS, 010 SEXT(imm), 011 ZEXT(imm), 100 zero, 101 shamt.
- `ex_ldst` out 3: 000 LB (default), 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `ex_jump_branch` out 4: 0000 none, 0001 J/JAL, 0010 JR/JALR, 0011 BEQ, 0100 BNE, 0101 BLEZ, 0110 BGTZ, 0111 BLTZ, 1000 BGEZ.
- `ex_wdest` out 5: resolved destination: rd for R-type, rt for I-type, 31 for JAL.
- `ex_opcode`, `ex_funct` out 6 each: passed to ALUdec.
- `mem_valid`, `mem_reg_write`, `mem_mem_to_reg` out 1 each; `mem_ldst` out 3; `mem_wdest` out 5: MEM-stage copy.
- `ill_count` out `ILL_CNT_W`: saturating count of illegal instructions accepted into EX.

## Operation
- Decode is combinational from `inst`, using the MIPS-I encodings in Opcode.vh.
  - Legal R-type functs: SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU.
  - Legal opcodes: J, JAL, BEQ, BNE, BLEZ, BGTZ, REGIMM, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LB, LH, LW, LBU, LHU, SB, SH, SW.
  - REGIMM with rt=00000 decodes as BLTZ and rt=00001 as BGEZ. Any other REGIMM rt is illegal.
- Control values per class:
  - Shifts: alu_src_b 101 (immediate form) or 001 (variable form); alu_reg_sel 1.
  - Loads, stores, ADDIU, SLTI, SLTIU: alu_src_b 010.
  - ANDI, ORI, XORI, LUI: alu_src_b 011.
  - BLEZ, BGTZ, BLTZ, BGEZ: alu_src_b 100.
  - Everything else: alu_src_b 000.
  - JAL and JALR: pc_plus8 1.
  - reg_write is 0 for stores, J, JR and branches.
  - mem_to_reg is 1 for loads only.
- Illegal instruction: the bundle is all zeros except `valid`=1 and `illegal`=1. `ill_count` increments when the instruction is accepted into EX and saturates at all-ones.
- Source use for hazard checks:
  - rs is used by every instruction except J, JAL, LUI, SLL, SRL and SRA.
  - rt is used by R-type (except JR and JALR), BEQ, BNE and stores.
- Load-use hazard fires when all of the following hold: `HAZARD_EN`, `inst_valid`, `ex_valid`, `ex_mem_to_reg`, `ex_wdest`≠0, and a used source equals `ex_wdest`.
- Priority, evaluated each cycle:
  1. `stall_in`=1: EX and MEM hold their contents. If `flush`=1 this cycle, `flush_pend` is set. `id_stall`=1.
  2. Otherwise, if `flush` or `flush_pend` is set: EX takes a bubble (all zeros, valid=0), MEM takes EX, and `flush_pend` clears. `id_stall`=0.
  3. Otherwise, on a load-use hazard: EX takes a bubble, MEM takes EX, and `id_stall`=1.
  4. Otherwise: EX takes the decode of `inst` (a bubble if `inst_valid`=0), and MEM takes EX.
- With `ZERO_WB_SUPPRESS`=1, `reg_write` is stored as 0 whenever `wdest`=0.

## Timing
- Reset (asynchronous): every `ex_*` and `mem_*` output is 0, `ill_count` is 0, and `flush_pend` is 0. `id_stall` is combinational and evaluates to 0 when `stall_in`=0.
- Latency: an instruction accepted at edge N appears on `ex_*` after N and on `mem_*` after N+1.
- `id_stall` is combinational from the current inputs plus EX state. There is no registered delay.
- A load-use stall lasts exactly one cycle: after the bubble, `ex_mem_to_reg`=0 so the hazard condition clears.
- `flush` coinciding with a load-use hazard: the flush wins, `id_stall`=0, and there is a single bubble.
- A reset asserted mid-stall or mid-flush clears all state immediately. No pending flush survives reset.

## Test plan
- Reset, then ADDU $3,$1,$2 (0x00221821) with `inst_valid`=1: one edge later, `ex_valid`=1, `ex_reg_write`=1, `ex_wdest`=3, `ex_alu_src_b`=000. One further edge later, `mem_wdest`=3.
- LW $5,0($4) followed by ADDU $6,$5,$0: `id_stall`=1 for one cycle and EX shows a bubble (`ex_valid`=0). ADDU reaches EX on the next edge. Repeat with `HAZARD_EN`=0: no stall.
- `stall_in`=1 for 3 cycles with `flush` pulsed in the 2nd cycle: EX and MEM are frozen throughout. On the first free edge EX becomes a bubble, then `flush_pend` is 0.
- REGIMM with rt=00001: `ex_jump_branch`=1000 and `ex_alu_src_b`=100. With rt=00010: `ex_illegal`=1 and `ill_count`=1. After 300 illegal instructions with `ILL_CNT_W`=8, `ill_count`=255.
- ADDIU $0,$1,5: `ex_reg_write`=0 with `ZERO_WB_SUPPRESS`=1 and 1 with `ZERO_WB_SUPPRESS`=0. JAL: `ex_wdest`=31, `ex_pc_plus8`=1, `ex_jump_branch`=0001.
- Assert `rst` asynchronously while `flush_pend`=1 and EX is valid: all outputs go to 0 before the next edge, and the first post-reset instruction enters EX with no bubble.
